// File: rtl/note_mix_pwm.sv
// note_mix_pwm: per-voice attack/release envelopes on three square-wave voices,
// summed and played on one PWM pin. Gated voices ramp in and out instead of
// switching hard, so key presses and releases do not click.

// One voice envelope: a linear ramp up while the key is held, and a linear ramp down after release.
module note_env_voice #(
    parameter int ENV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             gate_s,
    output logic [ENV_W-1:0] level,
    output logic             active
);
    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

    localparam logic [ENV_W-1:0] LVL_MAX = {ENV_W{1'b1}};

    env_state_t       state_q, state_d;
    logic [ENV_W-1:0] level_q, level_d;
    logic             active_q, active_d;

    // Gate transition first, then the tick step under the new state, then end-of-ramp hand-off
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        unique case (state_q)
            IDLE: begin
                level_d = '0;
                if (gate_s) state_d = ATTACK;
            end
            ATTACK:  if (!gate_s) state_d = RELEASE;
            SUSTAIN: if (!gate_s) state_d = RELEASE;
            RELEASE: if (gate_s)  state_d = ATTACK;
            default: state_d = IDLE;
        endcase
        // A retrigger from RELEASE resumes from the current level; both ends saturate
        if (tick) begin
            if (state_d == ATTACK && level_d != LVL_MAX)
                level_d = level_d + ENV_W'(1);
            else if (state_d == RELEASE && level_d != '0)
                level_d = level_d - ENV_W'(1);
        end
        if (state_d == ATTACK && level_d == LVL_MAX)
            state_d = SUSTAIN;
        else if (state_d == RELEASE && level_d == '0)
            state_d = IDLE;
        active_d = (state_d != IDLE);
    end

    // Envelope state, level and registered activity flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            level_q  <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            active_q <= active_d;
        end
    end

    assign level  = level_q;
    assign active = active_q;
endmodule

// Top: input sync, shared envelope prescaler, three voices, mixer and PWM.
module note_mix_pwm #(
    parameter int ENV_W        = 8,
    parameter int ENV_STEP_DIV = 1024,
    parameter int PWM_W        = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] tone_in,
    input  logic [2:0] gate_in,
    output logic       pwm_out,
    output logic [2:0] active
);
    localparam int NUM_VOICES = 3;
    localparam int SUM_W      = ENV_W + 2;
    localparam int PRE_W      = $clog2(ENV_STEP_DIV);

    logic [NUM_VOICES-1:0] tone_meta_q, tone_meta_d, tone_s_q, tone_s_d;
    logic [NUM_VOICES-1:0] gate_meta_q, gate_meta_d, gate_s_q, gate_s_d;
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic                  tick;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [SUM_W-1:0]      duty_q, duty_d;
    logic [PWM_W-1:0]      pcnt_q, pcnt_d;
    logic                  pwm_q, pwm_d;

    logic [NUM_VOICES-1:0][ENV_W-1:0] level;
    logic [NUM_VOICES-1:0]            voice_active;

    // Two-flop synchronisers for the asynchronous tone and button inputs
    always_comb begin
        tone_meta_d = tone_in;
        tone_s_d    = tone_meta_q;
        gate_meta_d = gate_in;
        gate_s_d    = gate_meta_q;
    end

    // Shared prescaler: one envelope step every ENV_STEP_DIV clocks
    assign tick = (presc_q == PRE_W'(ENV_STEP_DIV - 1));
    always_comb begin
        presc_d = tick ? '0 : presc_q + PRE_W'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            note_env_voice #(.ENV_W(ENV_W)) u_voice (
                .clk    (clk),
                .rst_n  (rst_n),
                .tick   (tick),
                .gate_s (gate_s_q[gi]),
                .level  (level[gi]),
                .active (voice_active[gi])
            );
        end
    endgenerate

    // Mixer: voices whose tone is high contribute their envelope level; sum cannot overflow
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            if (tone_s_q[i]) sum_d = sum_d + SUM_W'(level[i]);
    end

    // PWM: duty is only taken at the last count so a period never changes mid-way
    always_comb begin
        pcnt_d = pcnt_q + PWM_W'(1);
        duty_d = (pcnt_q == {PWM_W{1'b1}}) ? sum_q : duty_q;
        pwm_d  = (pcnt_d < PWM_W'(duty_d));
    end

    // All datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tone_meta_q <= '0;
            tone_s_q    <= '0;
            gate_meta_q <= '0;
            gate_s_q    <= '0;
            presc_q     <= '0;
            sum_q       <= '0;
            duty_q      <= '0;
            pcnt_q      <= '0;
            pwm_q       <= 1'b0;
        end else begin
            tone_meta_q <= tone_meta_d;
            tone_s_q    <= tone_s_d;
            gate_meta_q <= gate_meta_d;
            gate_s_q    <= gate_s_d;
            presc_q     <= presc_d;
            sum_q       <= sum_d;
            duty_q      <= duty_d;
            pcnt_q      <= pcnt_d;
            pwm_q       <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;
    assign active  = voice_active;
endmodule
